// File: rtl/cu_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control unit:
// FSM states, instruction classes, opcode patterns and ALU function codes.
package cu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_INV,
        C_ADD,
        C_SUB,
        C_AND,
        C_ORR,
        C_ADDI,
        C_LDUR,
        C_STUR,
        C_B,
        C_CBZ
    } iclass_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01001;
    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_ORR   = 5'b00100;
    localparam logic [4:0] FS_PASSA = 5'b10000;

    // rd_rt carries ir[4:0]: Rd for R/I-type, Rt for D-type and CBZ.
    typedef struct packed {
        iclass_e     cls;
        logic [4:0]  rd_rt;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] k;
        logic [63:0] br_off;
    } dec_t;

    function automatic logic [4:0] fs_of(input iclass_e cls);
        case (cls)
            C_SUB:   return FS_SUB;
            C_AND:   return FS_AND;
            C_ORR:   return FS_ORR;
            C_CBZ:   return FS_PASSA;
            default: return FS_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational decode of the instruction register into a class,
// register fields, extended immediate and byte-scaled branch offset.
module instr_decode
    import cu_pkg::*;
(
    input  logic [31:0] ir_i,
    output dec_t        dec_o
);

    iclass_e cls;

    always_comb begin
        if      (ir_i[31:21] == OP_ADD)  cls = C_ADD;
        else if (ir_i[31:21] == OP_SUB)  cls = C_SUB;
        else if (ir_i[31:21] == OP_AND)  cls = C_AND;
        else if (ir_i[31:21] == OP_ORR)  cls = C_ORR;
        else if (ir_i[31:22] == OP_ADDI) cls = C_ADDI;
        else if (ir_i[31:21] == OP_LDUR) cls = C_LDUR;
        else if (ir_i[31:21] == OP_STUR) cls = C_STUR;
        else if (ir_i[31:26] == OP_B)    cls = C_B;
        else if (ir_i[31:24] == OP_CBZ)  cls = C_CBZ;
        else                             cls = C_INV;
    end

    always_comb begin
        dec_o        = '0;
        dec_o.cls    = cls;
        dec_o.rd_rt  = ir_i[4:0];
        dec_o.rn     = ir_i[9:5];
        dec_o.rm     = ir_i[20:16];
        case (cls)
            C_ADDI:         dec_o.k = {52'b0, ir_i[21:10]};
            C_LDUR, C_STUR: dec_o.k = {{55{ir_i[20]}}, ir_i[20:12]};
            // Branch offsets are word counts; scale to bytes here.
            C_B:            dec_o.br_off = {{36{ir_i[25]}}, ir_i[25:0], 2'b00};
            C_CBZ:          dec_o.br_off = {{43{ir_i[23]}}, ir_i[23:5], 2'b00};
            default:        ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle LEGv8 control unit: owns the FSM, pc and instruction register,
// and drives the datapath control word from state and decoded instruction.
module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic [4:0]  status,
    output logic [63:0] pc,
    output logic        imem_en,
    output logic        halted,
    output logic [63:0] k,
    output logic [4:0]  reg_addr,
    output logic [4:0]  a_addr,
    output logic [4:0]  b_addr,
    output logic [4:0]  fs,
    output logic        reg_w,
    output logic        b_sel,
    output logic        b_en,
    output logic        alu_en,
    output logic        mem_en,
    output logic        chip_sel,
    output logic        mem_w,
    output logic        mem_r,
    output logic        stat_en,
    output logic        c0
);

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    dec_t        dec;
    logic        unused_status;

    // Only the live zero flag steers control; the other flags belong to the datapath.
    assign unused_status = ^status[4:1];

    instr_decode u_decode (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (dec.cls)
                    C_INV:   state_d = S_HALT;
                    C_LDUR:  state_d = S_MEM;
                    C_B:     pc_d = pc_q + dec.br_off;
                    C_CBZ:   pc_d = status[0] ? pc_q + dec.br_off : pc_q + 64'd4;
                    default: pc_d = pc_q + 64'd4;
                endcase
            end
            S_MEM: begin
                pc_d    = pc_q + 64'd4;
                state_d = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_en  = 1'b0;
        k        = '0;
        reg_addr = '0;
        a_addr   = '0;
        b_addr   = '0;
        fs       = '0;
        reg_w    = 1'b0;
        b_sel    = 1'b0;
        b_en     = 1'b0;
        alu_en   = 1'b0;
        mem_en   = 1'b0;
        chip_sel = 1'b0;
        mem_w    = 1'b0;
        mem_r    = 1'b0;
        stat_en  = 1'b0;
        c0       = 1'b0;
        case (state_q)
            S_FETCH: imem_en = 1'b1;
            S_EXEC: begin
                case (dec.cls)
                    C_ADD, C_SUB, C_AND, C_ORR, C_ADDI: begin
                        a_addr   = dec.rn;
                        b_addr   = dec.rm;
                        b_sel    = (dec.cls == C_ADDI);
                        k        = dec.k;
                        fs       = fs_of(dec.cls);
                        alu_en   = 1'b1;
                        reg_w    = 1'b1;
                        reg_addr = dec.rd_rt;
                        stat_en  = 1'b1;
                        c0       = (dec.cls == C_SUB);
                    end
                    C_STUR: begin
                        a_addr = dec.rn;
                        b_addr = dec.rd_rt;
                        b_sel  = 1'b1;
                        k      = dec.k;
                        fs     = FS_ADD;
                        mem_en = 1'b1;
                        b_en   = 1'b1;
                        mem_w  = 1'b1;
                    end
                    C_LDUR: begin
                        a_addr = dec.rn;
                        b_sel  = 1'b1;
                        k      = dec.k;
                        fs     = FS_ADD;
                        mem_en = 1'b1;
                        mem_r  = 1'b1;
                    end
                    C_CBZ: begin
                        a_addr = dec.rd_rt;
                        fs     = FS_PASSA;
                    end
                    default: ;
                endcase
            end
            // Load write-back: address held so the memory keeps driving the bus.
            S_MEM: begin
                a_addr   = dec.rn;
                b_sel    = 1'b1;
                k        = dec.k;
                fs       = FS_ADD;
                mem_en   = 1'b1;
                mem_r    = 1'b1;
                chip_sel = 1'b1;
                reg_w    = 1'b1;
                reg_addr = dec.rd_rt;
            end
            default: ;
        endcase
    end

    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected fetch addresses, control words
// and halt events are queued up front and matched by a negedge monitor.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] instr = '0;
    logic [4:0]  status;
    logic [63:0] pc, k;
    logic        imem_en, halted;
    logic [4:0]  reg_addr, a_addr, b_addr, fs;
    logic        reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, c0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .status(status),
        .pc(pc), .imem_en(imem_en), .halted(halted), .k(k),
        .reg_addr(reg_addr), .a_addr(a_addr), .b_addr(b_addr), .fs(fs),
        .reg_w(reg_w), .b_sel(b_sel), .b_en(b_en), .alu_en(alu_en),
        .mem_en(mem_en), .chip_sel(chip_sel), .mem_w(mem_w), .mem_r(mem_r),
        .stat_en(stat_en), .c0(c0)
    );

    localparam logic [9:0] F_REGW = 10'b1000000000, F_BSEL = 10'b0100000000,
                           F_BEN  = 10'b0010000000, F_ALU  = 10'b0001000000,
                           F_MEM  = 10'b0000100000, F_CS   = 10'b0000010000,
                           F_MW   = 10'b0000001000, F_MR   = 10'b0000000100,
                           F_ST   = 10'b0000000010, F_C0   = 10'b0000000001;
    localparam logic [4:0] X_ADD = 5'b01000, X_SUB = 5'b01001, X_AND = 5'b00000,
                           X_ORR = 5'b00100, X_PASSA = 5'b10000;

    typedef struct {
        int          kind;   // 0 fetch pc, 1 control word, 2 halt entry pc
        logic [94:0] cw;
        logic [94:0] mask;
        logic [63:0] pc;
        string       name;
    } obs_t;

    obs_t        expq[$];
    int          errors = 0, checks = 0;
    int          excl_viol = 0, abort_pulses = 0, cbz_cnt = 0;
    logic [31:0] rom [64];
    logic        z = 1'b0, halted_prev = 1'b0;
    bit          rand_mode = 0, mon_en = 0, watch_abort = 0;

    assign status = {4'b1010, z};

    // Instruction ROM: registered read, data valid the cycle after imem_en.
    always @(posedge clk) begin
        if (imem_en) begin
            instr <= rom[pc[7:2]];
            if (rand_mode) z <= 1'($urandom_range(0, 1));
            else if (pc == 64'd16) begin
                z       <= (cbz_cnt == 0);
                cbz_cnt <= cbz_cnt + 1;
            end
        end
    end

    function automatic logic [94:0] cw(input logic [63:0] kk, input logic [4:0] ra, aa, ba,
                                       input logic [4:0] f, input logic [9:0] fl);
        return {kk, ra, aa, ba, f, fl};
    endfunction

    function automatic logic [94:0] dut_cw();
        return cw(k, reg_addr, a_addr, b_addr, fs,
                  {reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, c0});
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_obs(input int kind, input string n, input logic [63:0] p,
                           input logic [94:0] c, input logic [94:0] m);
        obs_t o;
        o.kind = kind; o.name = n; o.pc = p; o.cw = c; o.mask = m;
        expq.push_back(o);
    endtask

    task automatic mon_step();
        int   kind;
        obs_t e;
        if ($countones({b_en, alu_en, chip_sel}) > 1) excl_viol++;
        if (watch_abort && (reg_w || mem_w)) abort_pulses++;
        kind = -1;
        if (halted && !halted_prev)  kind = 2;
        else if (imem_en)            kind = 0;
        else if (dut_cw() != '0)     kind = 1;
        halted_prev = halted;
        if (!mon_en || !rst || kind < 0) return;
        if (expq.size() == 0) begin
            chk("unexpected_event", 128'(kind), 128'(99));
            return;
        end
        e = expq.pop_front();
        chk({e.name, "_kind"}, 128'(kind), 128'(e.kind));
        if (e.kind == 1) chk(e.name, 128'(dut_cw() & e.mask), 128'(e.cw & e.mask));
        else             chk(e.name, 128'(pc), 128'(e.pc));
    endtask

    always @(negedge clk) mon_step();

    logic [94:0] m_full, m_r, m_ld, m_mem, m_st, m_cbz;

    task automatic exp_mid(input string tag, input logic [63:0] after_cbz);
        exp_obs(1, {"ldur_exec", tag}, 0, cw(64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 0, X_ADD, F_BSEL|F_MEM|F_MR), m_ld);
        exp_obs(1, {"ldur_mem", tag}, 0, cw(64'hFFFF_FFFF_FFFF_FFF8, 4, 1, 0, X_ADD, F_REGW|F_BSEL|F_CS), m_mem);
        exp_obs(0, {"pc12", tag}, 64'd12, '0, '0);
        exp_obs(1, {"stur", tag}, 0, cw(64'd3, 0, 2, 6, X_ADD, F_BSEL|F_MEM|F_BEN|F_MW), m_st);
        exp_obs(0, {"pc16", tag}, 64'd16, '0, '0);
        exp_obs(1, {"cbz", tag}, 0, cw(0, 0, 5, 0, X_PASSA, 10'b0), m_cbz);
        exp_obs(0, {"pc_after_cbz", tag}, after_cbz, '0, '0);
    endtask

    initial begin
        logic [31:0] w;
        bit          found;
        rst = 1'b0; start = 1'b0;
        m_full = '1;
        m_r    = ~cw('1, 0, 0, 0, 0, 0);
        m_ld   = ~cw(0, '1, 0, '1, 0, 0);
        m_mem  = ~cw(0, 0, 0, '1, 0, F_MEM|F_MR);
        m_st   = ~cw(0, '1, 0, 0, 0, 0);
        m_cbz  = ~cw('1, '1, 0, '1, 0, F_ALU);
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0] = {10'b1001000100, 12'd5, 5'd31, 5'd1};            // ADDI X1,X31,#5
        rom[1] = {11'b11001011000, 5'd2, 6'd0, 5'd1, 5'd3};       // SUB  X3,X1,X2
        rom[2] = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd4};    // LDUR X4,[X1,#-8]
        rom[3] = {11'b11111000000, 9'd3, 2'b00, 5'd2, 5'd6};      // STUR X6,[X2,#3]
        rom[4] = {8'b10110100, 19'h7FFFE, 5'd5};                  // CBZ  X5,#-2
        rom[5] = {11'b10001010000, 5'd9, 6'd0, 5'd8, 5'd7};       // AND  X7,X8,X9
        rom[6] = {11'b10101010000, 5'd12, 6'd0, 5'd11, 5'd10};    // ORR  X10,X11,X12
        rom[7] = {11'b10001011000, 5'd15, 6'd0, 5'd14, 5'd13};    // ADD  X13,X14,X15
        rom[8] = {6'b000101, 26'd3};                              // B    #3 -> 44

        #3;
        chk("rst_pc", 128'(pc), 128'(0));
        chk("rst_halted", 128'(halted), 128'(0));
        chk("rst_imem_en", 128'(imem_en), 128'(0));
        chk("rst_cw", 128'(dut_cw()), 128'(0));

        exp_obs(0, "pc0", 64'd0, '0, '0);
        exp_obs(1, "addi", 0, cw(64'd5, 1, 31, 0, X_ADD, F_REGW|F_BSEL|F_ALU|F_ST), m_full);
        exp_obs(0, "pc4", 64'd4, '0, '0);
        exp_obs(1, "sub", 0, cw(0, 3, 1, 2, X_SUB, F_REGW|F_ALU|F_ST|F_C0), m_r);
        exp_obs(0, "pc8", 64'd8, '0, '0);
        exp_mid("_a", 64'd8);
        exp_mid("_b", 64'd20);
        exp_obs(1, "and", 0, cw(0, 7, 8, 9, X_AND, F_REGW|F_ALU|F_ST), m_r);
        exp_obs(0, "pc24", 64'd24, '0, '0);
        exp_obs(1, "orr", 0, cw(0, 10, 11, 12, X_ORR, F_REGW|F_ALU|F_ST), m_r);
        exp_obs(0, "pc28", 64'd28, '0, '0);
        exp_obs(1, "add", 0, cw(0, 13, 14, 15, X_ADD, F_REGW|F_ALU|F_ST), m_r);
        exp_obs(0, "pc32", 64'd32, '0, '0);
        exp_obs(0, "pc44_branch", 64'd44, '0, '0);
        exp_obs(2, "halt_entry", 64'd44, '0, '0);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_wait_start", 128'(imem_en), 128'(0));
        mon_en = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400 && expq.size() > 0; i++) @(negedge clk);
        chk("queue_drained", 128'(expq.size()), 128'(0));
        repeat (3) @(negedge clk);
        chk("halt_pc_frozen", 128'(pc), 128'(44));
        chk("halt_held", 128'(halted), 128'(1));
        chk("halt_cw_zero", 128'(dut_cw()), 128'(0));
        mon_en = 0;
        rst = 1'b0;
        #1;
        chk("halt_rst_pc", 128'(pc), 128'(0));
        chk("halt_rst_halted", 128'(halted), 128'(0));

        rand_mode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) begin
                w = $urandom;
                case ($urandom_range(0, 9))
                    0: w[31:21] = 11'b10001011000;
                    1: w[31:21] = 11'b11001011000;
                    2: w[31:21] = 11'b10001010000;
                    3: w[31:21] = 11'b10101010000;
                    4: w[31:22] = 10'b1001000100;
                    5: w[31:21] = 11'b11111000010;
                    6: w[31:21] = 11'b11111000000;
                    7: w[31:26] = 6'b000101;
                    8: w[31:24] = 8'b10110100;
                    default: ;
                endcase
                rom[i] = w;
            end
            @(negedge clk);
            rst = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (150) @(negedge clk);
            rst = 1'b0;
        end
        rand_mode = 0;
        chk("bus_exclusive", 128'(excl_viol), 128'(0));

        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0] = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd4};
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_r) found = 1;
        end
        chk("ldur_exec_seen", 128'(found), 128'(1));
        rst = 1'b0; watch_abort = 1;
        #1;
        chk("abort_cw_zero", 128'(dut_cw()), 128'(0));
        chk("abort_pc", 128'(pc), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_write", 128'(abort_pulses), 128'(0));
        chk("abort_stays_idle", 128'(imem_en), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), and SHALL run on one clock with an asynchronous, active-low reset:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  begin execution from IDLE (level, sampled)
- instr  in  32  instruction word from instruction ROM; valid one cycle after imem_en
- status  in  5  datapath status {v,c,n,z,z_imm}; z_imm is the live ALU zero flag
- pc  out  64  program counter; also the instruction ROM address
- imem_en  out  1  instruction ROM read strobe
- halted  out  1  high while in HALT
- k  out  64  extended immediate
- reg_addr, a_addr, b_addr  out  5 each  register-file addresses
- fs  out  5  ALU function select
- reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, c0  out  1 each  datapath control word

Function
REQ-002 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM and HALT.
REQ-003 IDLE SHALL go to FETCH when start=1 and stay in IDLE otherwise.
REQ-004 FETCH SHALL assert imem_en=1 and go to DECODE.
REQ-005 DECODE SHALL latch instr into the instruction register and go to EXEC.
REQ-006 Supported opcodes are LEGv8: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDI 1001000100, LDUR 11111000010, STUR 11111000000, B 000101, CBZ 10110100.
REQ-007 Any other opcode, including 32'h0, SHALL go to HALT from EXEC with pc unchanged.
REQ-008 R-type instructions in EXEC SHALL drive:
- a_addr=Rn[9:5], b_addr=Rm[20:16], b_sel=0
- fs per opcode, alu_en=1, reg_w=1, reg_addr=Rd[4:0], stat_en=1
- then go to FETCH
REQ-009 ADDI SHALL be the same as an R-type add except b_sel=1 and k=zero-extended imm[21:10].
REQ-010 STUR SHALL complete in one EXEC cycle:
- a_addr=Rn, b_addr=Rt, b_sel=1, k=sign-extended imm[20:12]
- fs=ADD, mem_en=1, b_en=1, mem_w=1
REQ-011 LDUR SHALL use two cycles:
- EXEC: a_addr=Rn, b_sel=1, k=sign-extended imm[20:12], fs=ADD, mem_en=1, mem_r=1, then go to MEM
- MEM: the same address signals held, chip_sel=1, reg_w=1, reg_addr=Rt, then go to FETCH
REQ-012 CBZ in EXEC SHALL drive a_addr=Rt and fs=PASSA, and SHALL branch when status[0]=1.
REQ-013 B SHALL branch unconditionally.
REQ-014 On a branch, pc SHALL become pc + (sign-extended offset << 2):
- B offset: imm26
- CBZ offset: imm19[23:5]
REQ-015 Every non-branch, non-HALT instruction SHALL update pc to pc+4 at the end of its last cycle; pc arithmetic is 64-bit and wraps modulo 2^64.
REQ-016 At most one of b_en, alu_en and chip_sel SHALL be 1 in any cycle; this is the bus-exclusivity rule.
REQ-017 All control-word outputs SHALL be 0 in IDLE, FETCH, DECODE and HALT.
REQ-018 Control outputs SHALL be decoded combinationally from the current state and the instruction register only.
REQ-019 c0 SHALL be 1 only for SUB; stat_en SHALL be 0 for loads, stores and branches.
REQ-020 HALT SHALL hold halted=1 and leave only on reset.

Reset
REQ-021 rst=0 SHALL immediately force state=IDLE, pc=0, instruction register=0 and halted=0, and all control outputs to 0.
REQ-022 Reset asserted mid-instruction SHALL abort the instruction with no reg_w or mem_w pulse after assertion.
REQ-023 After rst deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-024 Package cu_pkg SHALL hold the following:
- state enum
- opcode constants
- FS codes: ADD 5'b01000, SUB 5'b01001, AND 5'b00000, ORR 5'b00100, PASSA 5'b10000
REQ-025 A combinational sub-module instr_decode SHALL map the instruction register to an instruction class, the register fields and the extended k.
REQ-026 control_unit SHALL own the FSM, pc and instruction register.

Verification
REQ-027 Reset, start, then ADDI X1,X31,#5 -> EXEC drives b_sel=1, k=5, fs=01000, reg_w=1, reg_addr=1, and pc=4 after 3 cycles.
REQ-028 SUB X3,X1,X2 -> c0=1, fs=01001, stat_en=1, a_addr=1, b_addr=2, reg_addr=3.
REQ-029 LDUR X4,[X1,#-8] -> k=64'hFFFF_FFFF_FFFF_FFF8, mem_r=1, then MEM with chip_sel=1 and reg_w=1, and pc advances 4 after 4 cycles.
REQ-030 CBZ X5,#-2 at pc=16:
- status[0]=1 -> pc=8
- status[0]=0 -> pc=20
REQ-031 Instruction 32'h0 -> HALT, halted=1, pc frozen; asserting rst=0 returns to IDLE with pc=0.
REQ-032 Random instruction stream -> bus-exclusivity assertion never fires, and reset pulsed mid-LDUR yields no reg_w.
